// File: rtl/load_mem_stage_if.sv
// Data-cache request/response bus between the load stage and the D$.
// The stage drives requests; the cache drives ready and response.
interface load_mem_stage_if #(
  parameter int LINE_BYTES = 8
);
  logic                    dc_req_valid;
  logic [31:0]             dc_req_addr;
  logic                    dc_req_ready;
  logic                    dc_resp_valid;
  logic [8*LINE_BYTES-1:0] dc_resp_data;

  modport master (
    output dc_req_valid,
    output dc_req_addr,
    input  dc_req_ready,
    input  dc_resp_valid,
    input  dc_resp_data
  );

  modport slave (
    input  dc_req_valid,
    input  dc_req_addr,
    output dc_req_ready,
    output dc_resp_valid,
    output dc_resp_data
  );
endinterface

// File: rtl/load_mem_stage.sv
// Load memory stage: one in-flight load, D$ request, byte extract/extend,
// result held for the completion arbiter.
module load_mem_stage #(
  parameter int TAG_W      = 6,
  parameter int ROB_W      = 5,
  parameter int LINE_BYTES = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [31:0]        in_addr,
  input  logic [2:0]         in_funct3,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [ROB_W-1:0]   in_rob,
  output logic               in_ready,
  input  logic               squash,
  load_mem_stage_if.master   dc,
  output logic               out_valid,
  output logic [31:0]        out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic [ROB_W-1:0]   out_rob,
  output logic               out_misaligned,
  input  logic               out_ready
);

  localparam int OFF_W = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t             state;
  logic [OFF_W-1:0]   off_q;
  logic [2:0]         f3_q;
  logic [TAG_W-1:0]   tag_q;
  logic [ROB_W-1:0]   rob_q;

  logic               mis;
  logic [31:0]        word;
  logic [31:0]        ext;

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      (in_funct3 == 3'b001),
      (in_funct3 == 3'b101): mis = in_addr[0];
      (in_funct3 == 3'b010): mis = (in_addr[1:0] != 2'b00);
      default:               mis = 1'b0;
    endcase
  end

  // aligned loads never straddle the line, so the low word is enough
  assign word = 32'(dc.dc_resp_data >> {off_q, 3'b000});

  always_comb begin
    ext = word;
    case (f3_q)
      3'b000:  ext = {{24{word[7]}}, word[7:0]};
      3'b001:  ext = {{16{word[15]}}, word[15:0]};
      3'b100:  ext = {24'b0, word[7:0]};
      3'b101:  ext = {16'b0, word[15:0]};
      default: ext = word;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      in_ready        <= 1'b1;
      dc.dc_req_valid <= 1'b0;
      dc.dc_req_addr  <= '0;
      out_valid       <= 1'b0;
      out_misaligned  <= 1'b0;
      out_data        <= '0;
      out_tag         <= '0;
      out_rob         <= '0;
      off_q           <= '0;
      f3_q            <= '0;
      tag_q           <= '0;
      rob_q           <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && !squash) begin
            off_q    <= in_addr[OFF_W-1:0];
            f3_q     <= in_funct3;
            tag_q    <= in_tag;
            rob_q    <= in_rob;
            in_ready <= 1'b0;
            if (mis) begin
              state          <= S_DONE;
              out_valid      <= 1'b1;
              out_misaligned <= 1'b1;
              out_data       <= '0;
              out_tag        <= in_tag;
              out_rob        <= in_rob;
            end else begin
              state           <= S_REQ;
              dc.dc_req_valid <= 1'b1;
              dc.dc_req_addr  <=
                {in_addr[31:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        S_REQ: begin
          if (squash) begin
            state           <= S_IDLE;
            dc.dc_req_valid <= 1'b0;
            in_ready        <= 1'b1;
          end else if (dc.dc_req_ready) begin
            state           <= S_WAIT;
            dc.dc_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (squash) begin
            if (dc.dc_resp_valid) begin
              state    <= S_IDLE;
              in_ready <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (dc.dc_resp_valid) begin
            state          <= S_DONE;
            out_valid      <= 1'b1;
            out_misaligned <= 1'b0;
            out_data       <= ext;
            out_tag        <= tag_q;
            out_rob        <= rob_q;
          end
        end
        S_DONE: begin
          if (squash || out_ready) begin
            state          <= S_IDLE;
            out_valid      <= 1'b0;
            out_misaligned <= 1'b0;
            in_ready       <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (dc.dc_resp_valid) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_mem_stage.sv
// Directed bench for load_mem_stage: hits, extension, misalign,
// back-pressure, squash and reset cases.
module tb_load_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [2:0]  in_funct3;
  logic [5:0]  in_tag;
  logic [4:0]  in_rob;
  logic        in_ready;
  logic        squash;
  logic        out_valid;
  logic [31:0] out_data;
  logic [5:0]  out_tag;
  logic [4:0]  out_rob;
  logic        out_misaligned;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  load_mem_stage_if #(.LINE_BYTES(8)) dc ();

  load_mem_stage #(
    .TAG_W(6),
    .ROB_W(5),
    .LINE_BYTES(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_addr        (in_addr),
    .in_funct3      (in_funct3),
    .in_tag         (in_tag),
    .in_rob         (in_rob),
    .in_ready       (in_ready),
    .squash         (squash),
    .dc             (dc.master),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_tag        (out_tag),
    .out_rob        (out_rob),
    .out_misaligned (out_misaligned),
    .out_ready      (out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] f3,
                       input logic [5:0] t, input logic [4:0] r);
    in_valid  = 1'b1;
    in_addr   = a;
    in_funct3 = f3;
    in_tag    = t;
    in_rob    = r;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_rqv"}, dc.dc_req_valid, 0);
  endtask

  // full hit with immediate handshakes; checks 3-cycle latency
  task automatic run_load(input string tag, input logic [31:0] a,
                          input logic [2:0] f3, input logic [63:0] line,
                          input logic [31:0] exp, input logic [5:0] t,
                          input logic [4:0] r);
    issue(a, f3, t, r);
    chk({tag, "_rqv"}, dc.dc_req_valid, 1);
    chk({tag, "_rqa"}, dc.dc_req_addr, {a[31:3], 3'b000});
    chk({tag, "_ov1"}, out_valid, 0);
    step();
    chk({tag, "_rqv2"}, dc.dc_req_valid, 0);
    dc.dc_resp_valid = 1'b1;
    dc.dc_resp_data  = line;
    step();
    dc.dc_resp_valid = 1'b0;
    dc.dc_resp_data  = '0;
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_mis"}, out_misaligned, 0);
    chk({tag, "_tag"}, out_tag, t);
    chk({tag, "_rob"}, out_rob, r);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    idle_chk({tag, "_end"});
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_rqv"}, dc.dc_req_valid, 0);
    chk({tag, "_rqa"}, dc.dc_req_addr, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_mis"}, out_misaligned, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_tag"}, out_tag, 0);
    chk({tag, "_rob"}, out_rob, 0);
  endtask

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_addr          = '0;
    in_funct3        = '0;
    in_tag           = '0;
    in_rob           = '0;
    squash           = 1'b0;
    out_ready        = 1'b0;
    dc.dc_req_ready  = 1'b1;
    dc.dc_resp_valid = 1'b0;
    dc.dc_resp_data  = '0;
    step();
    step();
    reset = 1'b0;
    reset_chk("rst");

    run_load("lw", 32'h1004, 3'b010, 64'h89AB_CDEF_0123_4567,
             32'h89AB_CDEF, 6'd5, 5'd3);
    run_load("lb", 32'h2003, 3'b000, 64'h0000_0000_8000_0000,
             32'hFFFF_FF80, 6'd7, 5'd4);
    run_load("lbu", 32'h2003, 3'b100, 64'h0000_0000_8000_0000,
             32'h0000_0080, 6'd8, 5'd5);
    run_load("lh", 32'h2002, 3'b001, 64'h0000_0000_8001_0000,
             32'hFFFF_8001, 6'd9, 5'd6);
    run_load("lhu", 32'h2006, 3'b101, 64'h8001_0000_0000_0000,
             32'h0000_8001, 6'd10, 5'd7);
    run_load("f3x", 32'h2000, 3'b011, 64'h1111_2222_F00D_BEEF,
             32'hF00D_BEEF, 6'd11, 5'd8);

    // misaligned LW faults without touching the cache
    issue(32'h3002, 3'b010, 6'd12, 5'd9);
    chk("mis_rqv", dc.dc_req_valid, 0);
    chk("mis_ov", out_valid, 1);
    chk("mis_flag", out_misaligned, 1);
    chk("mis_data", out_data, 0);
    chk("mis_tag", out_tag, 12);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    idle_chk("mis_end");
    run_load("post", 32'h3000, 3'b010, 64'h0000_0000_CAFE_F00D,
             32'hCAFE_F00D, 6'd13, 5'd10);

    issue(32'h3001, 3'b001, 6'd14, 5'd11);
    chk("mish_flag", out_misaligned, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // request back-pressure then output back-pressure
    dc.dc_req_ready = 1'b0;
    issue(32'h400C, 3'b010, 6'd15, 5'd12);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stl_rqv%0d", i), dc.dc_req_valid, 1);
      chk($sformatf("stl_rqa%0d", i), dc.dc_req_addr, 32'h4008);
      step();
    end
    dc.dc_req_ready = 1'b1;
    chk("stl_rqv4", dc.dc_req_valid, 1);
    step();
    chk("stl_wait", dc.dc_req_valid, 0);
    dc.dc_resp_valid = 1'b1;
    dc.dc_resp_data  = 64'h1234_5678_0000_0000;
    step();
    dc.dc_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_ov%0d", i), out_valid, 1);
      chk($sformatf("hold_d%0d", i), out_data, 32'h1234_5678);
      chk($sformatf("hold_rdy%0d", i), in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    idle_chk("hold_end");

    // squash in WAIT, response two cycles later is drained
    issue(32'h5000, 3'b010, 6'd16, 5'd13);
    step();
    squash = 1'b1;
    step();
    squash = 1'b0;
    chk("drn_rdy0", in_ready, 0);
    step();
    chk("drn_rdy1", in_ready, 0);
    dc.dc_resp_valid = 1'b1;
    dc.dc_resp_data  = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    dc.dc_resp_valid = 1'b0;
    idle_chk("drn_end");

    // squash coincident with the response
    issue(32'h5004, 3'b010, 6'd17, 5'd14);
    step();
    squash           = 1'b1;
    dc.dc_resp_valid = 1'b1;
    step();
    squash           = 1'b0;
    dc.dc_resp_valid = 1'b0;
    idle_chk("sqr");

    // squash in IDLE drops the load
    in_valid = 1'b1;
    squash   = 1'b1;
    in_addr  = 32'h6000;
    step();
    in_valid = 1'b0;
    squash   = 1'b0;
    idle_chk("sqi");

    // squash in DONE
    issue(32'h6001, 3'b010, 6'd18, 5'd15);
    chk("sqd_ov0", out_valid, 1);
    squash = 1'b1;
    step();
    squash = 1'b0;
    idle_chk("sqd");

    // reset in REQ
    issue(32'h7000, 3'b010, 6'd19, 5'd16);
    chk("rreq_rqv", dc.dc_req_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    reset_chk("rreq");

    // reset in DONE
    issue(32'h7004, 3'b010, 6'd20, 5'd17);
    step();
    dc.dc_resp_valid = 1'b1;
    dc.dc_resp_data  = 64'h5555_AAAA_0000_0000;
    step();
    dc.dc_resp_valid = 1'b0;
    chk("rdn_d0", out_data, 32'h5555_AAAA);
    reset = 1'b1;
    step();
    reset = 1'b0;
    reset_chk("rdn");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_mem_stage.md
Name: load_mem_stage

Overview:
Load-side memory stage directly downstream of the address-calculation FU. It accepts one computed effective address plus load metadata and issues a single request to the data cache. It waits for the response, then extracts and sign-/zero-extends the addressed bytes. The finished result is held for the completion/CDB arbiter until accepted; one load is in flight at a time.

Parameters:
TAG_W, 6, physical destination register tag width
ROB_W, 5, ROB index width carried for retirement bookkeeping
LINE_BYTES, 8, bytes per cache response word; power of two, at least 4

Ports:
clock  input  1  system clock
reset  input  1  synchronous active-high reset
in_valid  input  1  address-calc result valid this cycle
in_addr  input  32  effective address (rs1 + imm)
in_funct3  input  3  RV32 load funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101)
in_tag  input  TAG_W  destination physical register
in_rob  input  ROB_W  ROB index
in_ready  output  1  stage can accept a load this cycle
squash  input  1  branch mispredict flush; kills the in-flight load
dc_req_valid  output  1  cache request valid
dc_req_addr  output  32  line-aligned request address (low log2(LINE_BYTES) bits zero)
dc_req_ready  input  1  cache accepts request this cycle
dc_resp_valid  input  1  cache response valid (one-cycle pulse)
dc_resp_data  input  8*LINE_BYTES  response line
out_valid  output  1  completed load available
out_data  output  32  extended load result
out_tag  output  TAG_W  destination tag
out_rob  output  ROB_W  ROB index
out_misaligned  output  1  address fault; out_data is 0
out_ready  input  1  CDB/completion arbiter accepts output

Behaviour:
- Reset: state IDLE; in_ready=1. dc_req_valid, out_valid, out_misaligned are 0; out_data, out_tag, out_rob are 0; dc_req_addr is 0.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: in_ready=1. If in_valid and squash=0, latch addr, funct3, tag, rob.
  - Misaligned access (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0) -> DONE with out_misaligned=1, out_data=0. No cache request.
  - Otherwise -> REQ.
- Every state other than IDLE: in_ready=0. An in_valid arriving while in_ready=0 is a protocol violation; upstream holds the load.
- REQ: dc_req_valid=1, dc_req_addr = latched addr with low bits cleared. Stay in REQ until dc_req_ready=1, then -> WAIT.
- WAIT: on dc_resp_valid, select byte offset addr mod LINE_BYTES from dc_resp_data (byte 0 = bits [7:0]), extend per funct3, register the result, -> DONE.
  - A response arriving in the same cycle as the request handshake is ignored; responses arrive at least 1 cycle after acceptance.
- Extension: LB and LH sign-extend. LBU and LHU zero-extend. LW takes 32 bits. Unlisted funct3 values are treated as LW.
- DONE: out_valid=1, outputs stable until out_ready=1. On acceptance -> IDLE, out_valid=0 next cycle.
  - Earliest hit latency: in_valid at cycle 0 gives REQ in cycle 1; with dc_req_ready=1 in cycle 1 and dc_resp_valid in cycle 2, DONE/out_valid is in cycle 3.
- Squash, which takes priority over every other event in the same cycle:
  - In IDLE: the accompanying in_valid is dropped.
  - In REQ, or in DONE: -> IDLE next cycle, out_valid=0.
  - In WAIT without dc_resp_valid: -> DRAIN.
  - In WAIT with dc_resp_valid the same cycle: response discarded, -> IDLE.
- DRAIN: in_ready=0. Discard the next dc_resp_valid, then -> IDLE. Squash in DRAIN has no further effect.
- Reset mid-operation returns to IDLE immediately. Any outstanding cache response is the cache's responsibility; the cache is reset together with this stage.
- out_data, out_tag, out_rob hold their last values when out_valid=0; consumers qualify with out_valid.

Test Plan:
- LW hit, addr=0x1004, line=0x89ABCDEF_01234567, dc_req_ready and dc_resp_valid immediate -> dc_req_addr=0x1000, out_data=0x89ABCDEF, out_valid in cycle 3.
- LB and LBU at addr=0x2003, byte 3=0x80 -> LB returns 0xFFFFFF80, LBU returns 0x00000080. LH at 0x2002 with bytes 0x8001 -> 0xFFFF8001.
- LW at 0x3002 -> no dc_req_valid, out_valid with out_misaligned=1, out_data=0. The following aligned load proceeds normally.
- dc_req_ready held low 4 cycles -> dc_req_valid and dc_req_addr stable throughout. out_ready held low 3 cycles in DONE -> out_* stable, in_ready=0.
- Squash in WAIT, response 2 cycles later -> no out_valid, in_ready returns 1 the cycle after the discarded response. Squash coinciding with dc_resp_valid -> IDLE next cycle.
- Reset asserted in REQ and again in DONE -> next cycle all outputs 0, in_ready=1.
